// File: rtl/pulse_gen.sv
// ---------------------------------------------------------------------------
// pulse_gen
//   Programmable pulse-train transmitter for the IO test path. A single-cycle
//   start request launches num_pulses pulses. Each pulse is high_len cycles
//   high followed by max(low_len,1) cycles low. Every generated edge is also
//   reported as a one-cycle strobe, so a looped-back edge detector can be
//   compared against it one-for-one.
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   single-cycle request, sampled only while idle
//   abort       in   level; cancels a train in progress (wins over start)
//   high_len    in   [CNT_W] high-phase length, sampled with start
//   low_len     in   [CNT_W] low-phase length, sampled with start (0 -> 1)
//   num_pulses  in   [NUM_W] pulse count, sampled with start
//   dout        out  generated waveform (registered)
//   busy        out  train in progress (registered)
//   done        out  one-cycle completion strobe (registered)
//   pos_edge    out  high in the first cycle dout is 1 (registered)
//   neg_edge    out  high in the first cycle dout is 0 after a high phase
// ---------------------------------------------------------------------------
module pulse_gen #(
  parameter int CNT_W = 16,
  parameter int NUM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] high_len,
  input  logic [CNT_W-1:0] low_len,
  input  logic [NUM_W-1:0] num_pulses,
  output logic             dout,
  output logic             busy,
  output logic             done,
  output logic             pos_edge,
  output logic             neg_edge
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [NUM_W-1:0] NUM_ZERO = '0;
  localparam logic [NUM_W-1:0] NUM_ONE  = {{(NUM_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic [CNT_W-1:0] phase_cnt_r;   // cycles left in current phase, minus one
  logic [CNT_W-1:0] high_len_r;
  logic [CNT_W-1:0] low_len_r;     // already clamped to at least 1
  logic [NUM_W-1:0] rem_r;         // pulses still to run after the current one
  logic             dout_r;
  logic             busy_r;
  logic             done_r;
  logic             pos_edge_r;
  logic             neg_edge_r;

  logic [CNT_W-1:0] low_len_eff_s;
  logic             start_ok_s;

  // Clamp the requested low length to at least one cycle.
  always_comb begin
    low_len_eff_s = low_len;
    if (low_len == CNT_ZERO) begin
      low_len_eff_s = CNT_ONE;
    end else begin
      low_len_eff_s = low_len;
    end
  end

  // A start produces a waveform only with a non-empty train and high phase.
  always_comb begin
    start_ok_s = 1'b0;
    if ((num_pulses != NUM_ZERO) && (high_len != CNT_ZERO)) begin
      start_ok_s = 1'b1;
    end else begin
      start_ok_s = 1'b0;
    end
  end

  // Train sequencer: state, phase counters and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      phase_cnt_r <= CNT_ZERO;
      high_len_r  <= CNT_ZERO;
      low_len_r   <= CNT_ZERO;
      rem_r       <= NUM_ZERO;
      dout_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pos_edge_r  <= 1'b0;
      neg_edge_r  <= 1'b0;
    end else begin
      // Strobes are one cycle wide unless re-asserted below.
      done_r     <= 1'b0;
      pos_edge_r <= 1'b0;
      neg_edge_r <= 1'b0;

      case (state_r)
        S_IDLE: begin
          dout_r <= 1'b0;
          busy_r <= 1'b0;
          // Abort in the same cycle drops the start entirely.
          if (start && !abort) begin
            if (start_ok_s) begin
              high_len_r  <= high_len;
              low_len_r   <= low_len_eff_s;
              rem_r       <= num_pulses - NUM_ONE;
              phase_cnt_r <= high_len - CNT_ONE;
              state_r     <= S_HIGH;
              dout_r      <= 1'b1;
              busy_r      <= 1'b1;
              pos_edge_r  <= 1'b1;
            end else begin
              // Degenerate request: acknowledge so the requester never hangs.
              done_r <= 1'b1;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end

        S_HIGH: begin
          if (abort) begin
            state_r    <= S_IDLE;
            dout_r     <= 1'b0;
            busy_r     <= 1'b0;
            neg_edge_r <= dout_r;
          end else if (phase_cnt_r == CNT_ZERO) begin
            state_r     <= S_LOW;
            dout_r      <= 1'b0;
            neg_edge_r  <= 1'b1;
            phase_cnt_r <= low_len_r - CNT_ONE;
          end else begin
            phase_cnt_r <= phase_cnt_r - CNT_ONE;
          end
        end

        S_LOW: begin
          if (abort) begin
            state_r    <= S_IDLE;
            dout_r     <= 1'b0;
            busy_r     <= 1'b0;
            neg_edge_r <= dout_r;
          end else if (phase_cnt_r == CNT_ZERO) begin
            if (rem_r != NUM_ZERO) begin
              rem_r       <= rem_r - NUM_ONE;
              state_r     <= S_HIGH;
              dout_r      <= 1'b1;
              pos_edge_r  <= 1'b1;
              phase_cnt_r <= high_len_r - CNT_ONE;
            end else begin
              // Final low phase has run in full; finish the train.
              state_r <= S_IDLE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end
          end else begin
            phase_cnt_r <= phase_cnt_r - CNT_ONE;
          end
        end

        default: begin
          state_r <= S_IDLE;
          dout_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign dout     = dout_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign pos_edge = pos_edge_r;
  assign neg_edge = neg_edge_r;

endmodule

// File: tb/tb_pulse_gen.sv
// ---------------------------------------------------------------------------
// tb_pulse_gen
//   Directed bench for pulse_gen: a table of per-cycle vectors for short
//   trains and rejected starts, plus hand-written sequences for abort, async
//   reset, ignored restarts, the maximum high length and edge loopback.
//   Outputs are packed as {dout, busy, done, pos_edge, neg_edge}.
// ---------------------------------------------------------------------------
module tb_pulse_gen;

  localparam int CNT_W = 10;
  localparam int NUM_W = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] high_len;
  logic [CNT_W-1:0] low_len;
  logic [NUM_W-1:0] num_pulses;
  logic             dout;
  logic             busy;
  logic             done;
  logic             pos_edge;
  logic             neg_edge;

  int n_vec;
  int n_err;

  // Single-flop edge detector fed from dout, as the receiver would see it.
  logic lb_prev_r;
  int   lb_rise_r;
  int   lb_fall_r;

  typedef struct {
    logic       start;
    logic       abort;
    int         h;
    int         l;
    int         n;
    logic [4:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];

  pulse_gen #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .high_len   (high_len),
    .low_len    (low_len),
    .num_pulses (num_pulses),
    .dout       (dout),
    .busy       (busy),
    .done       (done),
    .pos_edge   (pos_edge),
    .neg_edge   (neg_edge)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) begin
      lb_prev_r <= 1'b0;
      lb_rise_r <= 0;
      lb_fall_r <= 0;
    end else begin
      lb_prev_r <= dout;
      if (dout && !lb_prev_r) lb_rise_r <= lb_rise_r + 1;
      if (!dout && lb_prev_r) lb_fall_r <= lb_fall_r + 1;
    end
  end

  function automatic vec_t mk(input logic s, input logic a, input int h,
                              input int l, input int n, input logic [4:0] e,
                              input string nm);
    vec_t v;
    v.start = s; v.abort = a; v.h = h; v.l = l; v.n = n; v.exp = e; v.name = nm;
    return v;
  endfunction

  task automatic check(input string nm, input logic [4:0] exp);
    logic [4:0] got;
    got = {dout, busy, done, pos_edge, neg_edge};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: dout/busy/done/pos/neg got %b expected %b (t=%0t)",
               nm, got, exp, $time);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then move to just after the active edge.
  task automatic cyc(input logic s, input logic a, input int h, input int l,
                     input int n);
    @(negedge clk);
    start      = s;
    abort      = a;
    high_len   = h[CNT_W-1:0];
    low_len    = l[CNT_W-1:0];
    num_pulses = n[NUM_W-1:0];
    @(posedge clk);
    #1;
  endtask

  // Run a full train, checking every cycle against the closed-form timing.
  // If extra_at > 0, a conflicting start is issued in that cycle of the train.
  task automatic run_train(input string nm, input int h, input int l,
                           input int n, input int extra_at);
    int le, p, total, c, r0, f0;
    logic [4:0] e;
    le    = (l == 0) ? 1 : l;
    p     = h + le;
    total = n * p;
    r0    = lb_rise_r;
    f0    = lb_fall_r;
    cyc(1'b1, 1'b0, h, l, n);
    for (int t = 1; t <= total + 2; t++) begin
      c = t - 1;
      e[4] = (c < total) && ((c % p) < h);
      e[3] = (t <= total);
      e[2] = (t == total + 1);
      e[1] = (c < total) && ((c % p) == 0);
      e[0] = (c < total) && ((c % p) == h);
      check($sformatf("%s_t%0d", nm, t), e);
      if (t == extra_at) cyc(1'b1, 1'b0, 1, 1, 9);
      else               cyc(1'b0, 1'b0, 0, 0, 0);
    end
    check_int({nm, "_loop_rise"}, lb_rise_r - r0, n);
    check_int({nm, "_loop_fall"}, lb_fall_r - f0, n);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    high_len = '0;
    low_len = '0;
    num_pulses = '0;

    // Reset then idle.
    repeat (3) @(posedge clk);
    #1;
    check("in_reset", 5'b00000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b0, 0, 0, 0);
      check($sformatf("idle_%0d", i), 5'b00000);
    end

    // Vector table: inputs for cycle T, expected outputs at T+1.
    // Single pulse H=3 L=2 N=1.
    vecs.push_back(mk(1'b1, 1'b0, 3, 2, 1, 5'b11010, "sp_t1"));
    vecs.push_back(mk(1'b0, 1'b0, 0, 0, 0, 5'b11000, "sp_t2"));
    vecs.push_back(mk(1'b0, 1'b0, 0, 0, 0, 5'b11000, "sp_t3"));
    vecs.push_back(mk(1'b0, 1'b0, 0, 0, 0, 5'b01001, "sp_t4"));
    vecs.push_back(mk(1'b0, 1'b0, 0, 0, 0, 5'b01000, "sp_t5"));
    vecs.push_back(mk(1'b0, 1'b0, 0, 0, 0, 5'b00100, "sp_t6"));
    vecs.push_back(mk(1'b0, 1'b0, 0, 0, 0, 5'b00000, "sp_t7"));
    // Train H=1 L=0 N=4: toggles every cycle, done at T+9.
    vecs.push_back(mk(1'b1, 1'b0, 1, 0, 4, 5'b11010, "l0_t1"));
    vecs.push_back(mk(1'b0, 1'b0, 0, 0, 0, 5'b01001, "l0_t2"));
    vecs.push_back(mk(1'b0, 1'b0, 0, 0, 0, 5'b11010, "l0_t3"));
    vecs.push_back(mk(1'b0, 1'b0, 0, 0, 0, 5'b01001, "l0_t4"));
    vecs.push_back(mk(1'b0, 1'b0, 0, 0, 0, 5'b11010, "l0_t5"));
    vecs.push_back(mk(1'b0, 1'b0, 0, 0, 0, 5'b01001, "l0_t6"));
    vecs.push_back(mk(1'b0, 1'b0, 0, 0, 0, 5'b11010, "l0_t7"));
    vecs.push_back(mk(1'b0, 1'b0, 0, 0, 0, 5'b01001, "l0_t8"));
    vecs.push_back(mk(1'b0, 1'b0, 0, 0, 0, 5'b00100, "l0_t9"));
    vecs.push_back(mk(1'b0, 1'b0, 0, 0, 0, 5'b00000, "l0_t10"));
    // Rejected starts: N=0 and H=0 give done only.
    vecs.push_back(mk(1'b1, 1'b0, 4, 4, 0, 5'b00100, "rej_n0"));
    vecs.push_back(mk(1'b0, 1'b0, 0, 0, 0, 5'b00000, "rej_n0_after"));
    vecs.push_back(mk(1'b1, 1'b0, 0, 4, 3, 5'b00100, "rej_h0"));
    vecs.push_back(mk(1'b0, 1'b0, 0, 0, 0, 5'b00000, "rej_h0_after"));
    // Abort with start in idle drops the start; abort alone in idle is inert.
    vecs.push_back(mk(1'b1, 1'b1, 3, 3, 2, 5'b00000, "abort_start_idle"));
    vecs.push_back(mk(1'b0, 1'b1, 0, 0, 0, 5'b00000, "abort_idle"));
    vecs.push_back(mk(1'b0, 1'b0, 0, 0, 0, 5'b00000, "abort_idle_after"));
    // Rejected start back-to-back with a real one.
    vecs.push_back(mk(1'b1, 1'b0, 2, 1, 0, 5'b00100, "rej_then_go"));
    vecs.push_back(mk(1'b1, 1'b0, 2, 1, 1, 5'b11010, "go_t1"));
    vecs.push_back(mk(1'b0, 1'b0, 0, 0, 0, 5'b11000, "go_t2"));
    vecs.push_back(mk(1'b0, 1'b0, 0, 0, 0, 5'b01001, "go_t3"));
    vecs.push_back(mk(1'b0, 1'b0, 0, 0, 0, 5'b00100, "go_t4"));

    foreach (vecs[i]) begin
      cyc(vecs[i].start, vecs[i].abort, vecs[i].h, vecs[i].l, vecs[i].n);
      check(vecs[i].name, vecs[i].exp);
    end
    cyc(1'b0, 1'b0, 0, 0, 0);

    // Restart ignored mid-train; done must still land at T+21.
    run_train("ign", 5, 5, 2, 3);

    // Abort in HIGH: start H=10 L=10 N=3, abort at T+4.
    cyc(1'b1, 1'b0, 10, 10, 3);
    check("ab_t1", 5'b11010);
    for (int i = 2; i <= 4; i++) begin
      cyc(1'b0, 1'b0, 0, 0, 0);
      check($sformatf("ab_t%0d", i), 5'b11000);
    end
    cyc(1'b0, 1'b1, 0, 0, 0);
    check("ab_t5", 5'b00001);
    cyc(1'b0, 1'b0, 0, 0, 0);
    check("ab_t6_no_done", 5'b00000);
    run_train("after_abort", 4, 2, 2, 0);

    // Abort in LOW: no neg_edge since dout is already 0.
    cyc(1'b1, 1'b0, 2, 5, 1);
    check("abl_t1", 5'b11010);
    cyc(1'b0, 1'b0, 0, 0, 0);
    check("abl_t2", 5'b11000);
    cyc(1'b0, 1'b0, 0, 0, 0);
    check("abl_t3", 5'b01001);
    cyc(1'b0, 1'b1, 0, 0, 0);
    check("abl_t4", 5'b00000);
    cyc(1'b0, 1'b0, 0, 0, 0);
    check("abl_t5_no_done", 5'b00000);

    // Maximum high length with L=1.
    run_train("hmax", (1 << CNT_W) - 1, 1, 1, 0);

    // Multi-pulse train with uneven phases.
    run_train("multi", 3, 4, 3, 0);

    // Async reset in the middle of a high phase.
    cyc(1'b1, 1'b0, 10, 1, 1);
    check("rst_t1", 5'b11010);
    cyc(1'b0, 1'b0, 0, 0, 0);
    check("rst_t2", 5'b11000);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_async", 5'b00000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 0, 0, 0);
      check($sformatf("rst_after_%0d", i), 5'b00000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pulse_gen.md
# pulse_gen

Edge/pulse transmitter for the IO test path: on a single-cycle start request it drives a programmable train of pulses on `dout` with cycle-exact high and low widths. It also reports every edge it generates. It is the stimulus side for the board IO loop. Its `dout` is looped back (externally or in simulation) into the edge-detector receiver, so generated edges and detected edges can be compared one-for-one.

## Interface
- `CNT_W`, default 16: width of the high/low length inputs and the internal phase counter.
- `NUM_W`, default 8: width of the pulse-count input and the remaining-pulse counter.
- `clk`  input  1  system clock. All logic is rising-edge.
- `rst_n`  input  1  reset. Asynchronous, active-low; clock `clk`.
- `start`  input  1  single-cycle request. Sampled only in IDLE.
- `abort`  input  1  level. Cancels any train in progress.
- `high_len`  input  CNT_W  high-phase length in cycles. Sampled with `start`.
- `low_len`  input  CNT_W  low-phase length in cycles. Sampled with `start`. A value of 0 is treated as 1.
- `num_pulses`  input  NUM_W  number of pulses. Sampled with `start`.
- `dout`  output  1  generated waveform. Registered.
- `busy`  output  1  high while a train is in progress. Registered.
- `done`  output  1  single-cycle completion strobe. Registered.
- `pos_edge`  output  1  single-cycle strobe, high in the first cycle `dout` is 1. Registered.
- `neg_edge`  output  1  single-cycle strobe, high in the first cycle `dout` is 0 after a high phase. Registered.

## Operation
- States: IDLE, HIGH, LOW.
- Reset (async): state IDLE. `dout`, `busy`, `done`, `pos_edge` and `neg_edge` are all 0. Counters are cleared.
- IDLE, `start`=1, `num_pulses`≠0 and `high_len`≠0:
  - Latch `high_len`, `max(low_len,1)` and `num_pulses`.
  - Go to HIGH.
- IDLE, `start`=1 with `num_pulses`=0 or `high_len`=0:
  - No waveform is generated and `busy` stays 0.
  - `done` pulses for one cycle, so the requester never hangs.
- HIGH: `dout`=1 for exactly the latched `high_len` cycles, then go to LOW.
- LOW: `dout`=0 for exactly the latched low length cycles. At the end of the phase:
  - If pulses remain, decrement the remaining count and go to HIGH.
  - Otherwise go to IDLE and pulse `done`.
- The final low phase is always emitted in full. The train therefore ends with a guaranteed minimum low time before `done`.
- `start` while `busy`=1 is ignored; no queuing. Input changes after the `start` cycle have no effect on a train in progress.
- `abort`=1 in HIGH or LOW:
  - Next cycle: state IDLE, `dout`=0, `busy`=0, no `done`.
  - `neg_edge` pulses if `dout` was 1.
- `abort`=1 and `start`=1 in the same cycle in IDLE: abort wins and the start is dropped.
- `abort`=1 in IDLE has no effect.
- Reset asserted mid-train: all outputs go to 0 immediately (async). No `done` and no `neg_edge` are emitted.
- Counters: the phase counter loads length−1 and counts down to 0. The full range 1..2^CNT_W−1 is legal, with no wrap. `num_pulses` up to 2^NUM_W−1 is legal.

## Timing
- Let T be the cycle `start` is sampled.
- `dout`, `busy` and `pos_edge` rise at T+1.
- With H = `high_len` and L = `max(low_len,1)`, for pulse k (k = 0..N−1):
  - Rise at T+1+k(H+L).
  - Fall at T+1+k(H+L)+H.
- `busy` is 1 from T+1 through T+N(H+L), inclusive.
- `done` is 1 at T+N(H+L)+1, the same cycle `busy` returns to 0.
- The earliest next accepted `start` is in the cycle `done` is high. The train then begins on the following cycle.
- Rejected `start` at T: `done` at T+1 only.
- `pos_edge` and `neg_edge` coincide exactly with the cycle `dout` changes. A looped-back single-flop edge detector sees each edge one cycle later.

## Test plan
- Reset then idle: hold `rst_n`=0 then release, no `start` for 20 cycles. All outputs stay 0.
- Single pulse: `start` at T with H=3, L=2, N=1.
  - `dout`=1 at T+1..T+3 and 0 at T+4..T+5.
  - `done` at T+6. `pos_edge` at T+1, `neg_edge` at T+4.
- Train with L=0: H=1, L=0, N=4. `dout` toggles every cycle T+1..T+8 (4 rises, 4 falls). `done` at T+9.
- Reject and ignore:
  - `start` with N=0 gives `done` at T+1 with `busy` never set.
  - A second `start` during a train of H=5, L=5, N=2 has no effect; `done` still at T+21.
- Abort: start H=10, L=10, N=3, then `abort` at T+4.
  - At T+5, `dout`=0, `busy`=0 and `neg_edge`=1.
  - No `done` follows. A new `start` at T+6 runs normally.
- Boundaries:
  - H=2^CNT_W−1, L=1, N=1 gives a high phase of exact length.
  - `rst_n` asserted mid-high clears all outputs asynchronously.
  - Loopback into the edge detector counts N rising and N falling edges.
